sfx_sequencer: RTL

Parametrised sound-effect sequencer for the game's buzzer path. It holds a writable pattern RAM of NUM_EVENTS note sequences of up to MAX_STEPS steps each. It latches event triggers and arbitrates them by fixed priority, with preemption and retrigger, and plays one sequence at a time as a NOTE_W-bit note index for the tone generator. It replaces the fixed-pattern buzzer logic and runs entirely on the system clock, using an internal tick prescaler instead of a derived clock.

---
 rtl/sfx_sequencer.sv | 213 +++++++++++++++++++++
 1 files changed

// File: rtl/sfx_sequencer.sv
// sfx_sequencer
//   Sound-effect sequencer for the buzzer path. It holds a writable pattern
//   RAM with NUM_EVENTS patterns of up to MAX_STEPS {note, duration} steps
//   each. Event triggers are latched as pending bits and served in fixed
//   priority order, with index 0 the highest. Higher-priority and same-event
//   triggers preempt the pattern that is playing. One note index is driven to
//   the tone generator. Step durations are counted in ticks of an internal
//   prescaler that wraps every TICK_DIV clk cycles.
//
// Ports
//   clk        system clock
//   reset      synchronous, active-high
//   enable     low = forced silence, pending flushed, triggers ignored
//   trig       one-cycle trigger pulse per event
//   wr_en      pattern RAM write strobe; wr_event/wr_step/wr_note/wr_dur qualify it
//   wr_dur     duration in ticks; 0 marks end-of-pattern
//   note       current note (0 = rest)
//   busy       high while a pattern is loading or playing
//   cur_event  event being played (valid when busy)
//   done       one-cycle pulse on natural pattern end
//   dbg_state  FSM state (0 IDLE, 1 LOAD, 2 PLAY)
//
// Strobes: trig and wr_en carry no handshake. Each cycle a strobe is high is
// consumed on that clock edge and can never be stalled.

module sfx_sequencer #(
   parameter int NUM_EVENTS = 5,
   parameter int MAX_STEPS  = 16,
   parameter int NOTE_W     = 6,
   parameter int DUR_W      = 8,
   parameter int TICK_DIV   = 131072,
   localparam int EV_W      = (NUM_EVENTS > 1) ? $clog2(NUM_EVENTS) : 1,
   localparam int ST_W      = $clog2(MAX_STEPS),
   localparam int PS_W      = $clog2(TICK_DIV)
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  enable,
   input  logic [NUM_EVENTS-1:0] trig,
   input  logic                  wr_en,
   input  logic [EV_W-1:0]       wr_event,
   input  logic [ST_W-1:0]       wr_step,
   input  logic [NOTE_W-1:0]     wr_note,
   input  logic [DUR_W-1:0]      wr_dur,
   output logic [NOTE_W-1:0]     note,
   output logic                  busy,
   output logic [EV_W-1:0]       cur_event,
   output logic                  done,
   output logic [1:0]            dbg_state
);

   typedef enum logic [1:0] {S_IDLE = 2'd0, S_LOAD = 2'd1, S_PLAY = 2'd2} state_t;

   localparam int AW = EV_W + ST_W;

   // Pattern RAM, addressed as {event, step}
   logic [NOTE_W+DUR_W-1:0] r_mem [2**AW];
   logic [NOTE_W+DUR_W-1:0] r_rd_data;

   state_t                  r_state, w_next_state;
   logic [NUM_EVENTS-1:0]   r_pending;
   logic [EV_W-1:0]         r_cur_event;
   logic [ST_W-1:0]         r_step;
   logic [DUR_W-1:0]        r_dur_cnt;
   logic [PS_W-1:0]         r_presc;
   logic [NOTE_W-1:0]       r_note;
   logic                    r_done;

   logic                    w_pend_any;
   logic [EV_W-1:0]         w_pend_idx;
   logic                    w_preempt, w_tick, w_expire;
   logic                    w_start, w_end, w_adv, w_capture;
   logic                    w_rd_en;
   logic [EV_W-1:0]         w_rd_ev;
   logic [ST_W-1:0]         w_rd_step;
   logic [NUM_EVENTS-1:0]   w_clr;
   logic [NOTE_W-1:0]       w_rd_note;
   logic [DUR_W-1:0]        w_rd_dur;

   assign w_rd_note = r_rd_data[NOTE_W+DUR_W-1:DUR_W];
   assign w_rd_dur  = r_rd_data[DUR_W-1:0];

   // Lowest set pending bit wins
   always_comb begin
      w_pend_any = |r_pending;
      w_pend_idx = '0;
      for (int i = NUM_EVENTS - 1; i >= 0; i--) begin
         if (r_pending[i]) w_pend_idx = EV_W'(i);
      end
   end

   // A pending event at or above the current priority takes over; equal index is a retrigger
   assign w_preempt = (r_state != S_IDLE) && w_pend_any && (w_pend_idx <= r_cur_event);
   assign w_tick    = (r_presc == PS_W'(TICK_DIV - 1));
   assign w_expire  = w_tick && (r_dur_cnt == DUR_W'(1));

   // FSM: state register
   always_ff @(posedge clk) begin
      if (reset) r_state <= S_IDLE;
      else       r_state <= w_next_state;
   end

   // FSM: next state and the control events it implies
   always_comb begin
      w_next_state = r_state;
      w_start      = 1'b0;
      w_end        = 1'b0;
      w_adv        = 1'b0;
      w_capture    = 1'b0;
      if (!enable) begin
         w_next_state = S_IDLE;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (w_pend_any) begin
                  w_start      = 1'b1;
                  w_next_state = S_LOAD;
               end
            end
            S_LOAD: begin
               if (w_preempt) begin
                  w_start      = 1'b1;
                  w_next_state = S_LOAD;
               end else if (w_rd_dur == '0) begin
                  w_end        = 1'b1;
                  w_next_state = S_IDLE;
               end else begin
                  w_capture    = 1'b1;
                  w_next_state = S_PLAY;
               end
            end
            S_PLAY: begin
               if (w_preempt) begin
                  w_start      = 1'b1;
                  w_next_state = S_LOAD;
               end else if (w_expire) begin
                  if (r_step == ST_W'(MAX_STEPS - 1)) begin
                     w_end        = 1'b1;
                     w_next_state = S_IDLE;
                  end else begin
                     w_adv        = 1'b1;
                     w_next_state = S_LOAD;
                  end
               end
            end
            default: w_next_state = S_IDLE;
         endcase
      end
   end

   // FSM: outputs and RAM read port control
   always_comb begin
      busy      = (r_state != S_IDLE);
      dbg_state = r_state;
      w_rd_en   = w_start | w_adv;
      w_rd_ev   = w_start ? w_pend_idx : r_cur_event;
      w_rd_step = w_start ? '0 : (r_step + ST_W'(1));
      w_clr     = w_start ? (NUM_EVENTS'(1) << w_pend_idx) : '0;
   end

   // Read-first RAM: a same-edge write never shows up in r_rd_data
   always_ff @(posedge clk) begin
      if (wr_en)   r_mem[{wr_event, wr_step}] <= {wr_note, wr_dur};
      if (w_rd_en) r_rd_data <= r_mem[{w_rd_ev, w_rd_step}];
   end

   // Datapath
   always_ff @(posedge clk) begin
      if (reset) begin
         r_pending   <= '0;
         r_cur_event <= '0;
         r_step      <= '0;
         r_dur_cnt   <= '0;
         r_presc     <= '0;
         r_note      <= '0;
         r_done      <= 1'b0;
      end else begin
         r_done <= w_end;
         if (!enable) begin
            r_pending <= '0;
            r_note    <= '0;
            r_presc   <= '0;
         end else begin
            // A trigger on the same edge its bit is consumed re-arms the bit
            r_pending <= (r_pending & ~w_clr) | trig;
            if (w_start) begin
               r_cur_event <= w_pend_idx;
               r_step      <= '0;
            end else if (w_adv) begin
               r_step <= r_step + ST_W'(1);
            end
            if (w_capture) begin
               r_note    <= w_rd_note;
               r_dur_cnt <= w_rd_dur;
               r_presc   <= '0;
            end else if (r_state == S_PLAY && !w_start) begin
               if (w_tick) begin
                  r_presc   <= '0;
                  r_dur_cnt <= r_dur_cnt - DUR_W'(1);
               end else begin
                  r_presc <= r_presc + PS_W'(1);
               end
            end
            if (w_end) r_note <= '0;
         end
      end
   end

   assign note      = r_note;
   assign cur_event = r_cur_event;
   assign done      = r_done;

endmodule
